otter_lsu: RTL and testbench

load/store initiator between the multicycle core and data port 2 of the dual-port memory. Splits word-spanning accesses, which the memory does not support, into legal memory transactions.

Interface
REQ-001 The module SHALL have parameter IO_BASE, default 32'h11000000, the lowest memory-mapped IO address.
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The module SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-004 The module SHALL have core-side inputs REQ (1), WE (1), ADDR (32), WDATA (32), SIZE (2; 0=byte, 1=half, 2=word, 3=reserved) and UNS (1; 1=zero-extend).
REQ-005 The module SHALL have core-side outputs BUSY (1), DONE (1, one-cycle pulse), RDATA (32) and ERR (1, valid with DONE).
REQ-006 The module SHALL have memory-side outputs MEM_ADDR2 (32), MEM_DIN2 (32), MEM_WRITE2 (1), MEM_READ2 (1), MEM_SIZE (2) and MEM_SIGN (1).
REQ-007 The module SHALL have memory-side input MEM_DOUT2 (32): read data, valid in the cycle after the cycle with MEM_READ2=1.

Function
REQ-008 States: IDLE, RD_LO, CAP_LO, RD_HI, CAP_HI, WR, RESP.
REQ-009 IDLE: BUSY=0, all memory strobes 0, MEM_ADDR2=0. A REQ sampled high is accepted; ADDR, WDATA, SIZE, UNS and WE are latched.
REQ-010 REQ is ignored in every state except IDLE; BUSY=1 in all non-IDLE states.
REQ-011 Span condition: ADDR[1:0] + bytes(SIZE) > 4, where bytes = 1, 2 or 4.
REQ-012 IO accesses (latched ADDR >= IO_BASE) never span and never split: one word access at the unmodified ADDR with MEM_SIZE=2; RDATA = MEM_DOUT2 unmodified.
REQ-013 SIZE=3: no memory strobe; next state is RESP with RDATA=0 and ERR=1. ERR=0 for all other requests.
REQ-014 Loads: RD_LO drives MEM_READ2=1, MEM_ADDR2={ADDR[31:2],2'b00}, MEM_SIZE=2, MEM_SIGN=0.
REQ-015 CAP_LO holds MEM_ADDR2 with MEM_READ2=0 and registers MEM_DOUT2 as the low word.
REQ-016 After CAP_LO, a spanning load goes to RD_HI; otherwise it goes to RESP.
REQ-017 RD_HI/CAP_HI repeat the RD_LO/CAP_LO behaviour at word address+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), and register the high word.
REQ-018 Load result: the 64-bit window {hi,lo} is shifted right by ADDR[1:0]*8 and truncated to the access size.
REQ-019 The truncated result is sign-extended when UNS=0 and zero-extended when UNS=1, then registered into RDATA on entry to RESP.
REQ-020 Non-spanning stores: a single WR cycle drives MEM_WRITE2=1, MEM_ADDR2=ADDR, MEM_SIZE=SIZE, MEM_DIN2=WDATA.
REQ-021 Spanning stores: one WR cycle per byte, k=bytes(SIZE), in ascending address order. Byte i uses MEM_SIZE=0, MEM_ADDR2=ADDR+i (mod 2^32), MEM_DIN2[7:0]=WDATA[8i+7:8i], upper bits 0.
REQ-022 A 2-bit byte counter SHALL track spanning-store progress.
REQ-023 RESP: DONE=1 for exactly one cycle, then unconditionally IDLE. RDATA holds its value until the next load completes; stores leave RDATA unchanged.
REQ-024 Latency, counted in rising edges from the accepting edge to DONE high: non-spanning load 2; spanning load 4; non-spanning store 1; spanning store k.
REQ-025 MEM_READ2 and MEM_WRITE2 SHALL never be high in the same cycle.

Reset
REQ-026 RST_N low at a rising edge SHALL force IDLE regardless of state and clear RDATA, the captured words and the byte counter.
REQ-027 During reset all strobes are 0, with DONE=0, ERR=0, BUSY=0 and MEM_ADDR2=0.
REQ-028 An operation in flight at reset SHALL be abandoned with no DONE and no further memory strobes; a partially completed spanning store is not rolled back.
REQ-029 REQ held high while RST_N is low SHALL NOT be accepted until the first edge with RST_N high.

Verification

---
 rtl/otter_lsu.sv | 198 +++++++++++++++++++
 tb/tb_otter_lsu.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_lsu.sv
// Load/store unit between the multicycle core and memory port 2. Word-spanning
// loads become two aligned word reads; word-spanning stores become byte writes.
module otter_lsu #(
    parameter logic [31:0] IO_BASE = 32'h11000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);
    typedef enum logic [2:0] {StIdle, StRdLo, StCapLo, StRdHi, StCapHi, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d, hi_q, hi_d, rdata_q, rdata_d;
    logic [1:0]  size_q, size_d, cnt_q, cnt_d;
    logic        uns_q, uns_d, err_q, err_d;

    logic [2:0]  nbytes;
    logic        is_io, span, last_byte;
    logic [31:0] word_addr, shifted, load_val, wshift;
    logic [63:0] window;

    always_comb begin
        case (size_q)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign is_io     = addr_q >= IO_BASE;
    assign span      = !is_io && (({1'b0, addr_q[1:0]} + nbytes) > 3'd4);
    assign word_addr = is_io ? addr_q : {addr_q[31:2], 2'b00};
    // Last byte index of a spanning store is 1 for halfwords and 3 for words.
    assign last_byte = cnt_q == {size_q[1], 1'b1};
    assign wshift    = wdata_q >> {cnt_q, 3'b000};

    assign lo_d = (state_q == StCapLo) ? MEM_DOUT2 : lo_q;
    assign hi_d = (state_q == StCapHi) ? MEM_DOUT2 : hi_q;

    always_comb begin
        window = {hi_d, lo_d} >> {addr_q[1:0], 3'b000};
        shifted = window[31:0];
        case (size_q)
            2'd0:    load_val = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
        if (is_io) begin
            load_val = MEM_DOUT2;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                    size_d  = SIZE;
                    uns_d   = UNS;
                    cnt_d   = 2'd0;
                    err_d   = SIZE == 2'd3;
                    if (SIZE == 2'd3) begin
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else if (WE) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRdLo;
                    end
                end
            end
            StRdLo:  state_d = StCapLo;
            StCapLo: begin
                if (span) begin
                    state_d = StRdHi;
                end else begin
                    rdata_d = load_val;
                    state_d = StResp;
                end
            end
            StRdHi:  state_d = StCapHi;
            StCapHi: begin
                rdata_d = load_val;
                state_d = StResp;
            end
            StWr: begin
                if (span && !last_byte) begin
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        BUSY       = state_q != StIdle;
        DONE       = state_q == StResp;
        ERR        = (state_q == StResp) && err_q;
        MEM_ADDR2  = 32'h0;
        MEM_DIN2   = 32'h0;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        MEM_SIZE   = 2'd0;
        MEM_SIGN   = 1'b0;
        case (state_q)
            StRdLo, StCapLo: begin
                MEM_READ2 = state_q == StRdLo;
                MEM_ADDR2 = word_addr;
                MEM_SIZE  = 2'd2;
            end
            StRdHi, StCapHi: begin
                MEM_READ2 = state_q == StRdHi;
                MEM_ADDR2 = word_addr + 32'd4;
                MEM_SIZE  = 2'd2;
            end
            StWr: begin
                MEM_WRITE2 = 1'b1;
                if (span) begin
                    MEM_ADDR2 = addr_q + {30'h0, cnt_q};
                    MEM_DIN2  = {24'h0, wshift[7:0]};
                end else begin
                    MEM_ADDR2 = addr_q;
                    MEM_SIZE  = is_io ? 2'd2 : size_q;
                    MEM_DIN2  = wdata_q;
                end
            end
            default: ;
        endcase
        // Outputs are quiet for the whole reset cycle, not only after the edge.
        if (!RST_N) begin
            BUSY       = 1'b0;
            DONE       = 1'b0;
            ERR        = 1'b0;
            MEM_ADDR2  = 32'h0;
            MEM_DIN2   = 32'h0;
            MEM_WRITE2 = 1'b0;
            MEM_READ2  = 1'b0;
            MEM_SIZE   = 2'd0;
        end
    end

    assign RDATA = rdata_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_otter_lsu.sv
// Bench for otter_lsu: directed vector table, reset/RESP corner sequences and a
// randomized run checked against a byte-addressed memory model.
module tb_otter_lsu;
    localparam logic [31:0] IoBase = 32'h11000000;

    logic        CLK = 1'b0, RST_N = 1'b0, REQ = 1'b0, WE = 1'b0, UNS = 1'b0;
    logic [31:0] ADDR = 32'h0, WDATA = 32'h0;
    logic [1:0]  SIZE = 2'd0;
    logic        BUSY, DONE, ERR, MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [31:0] RDATA, MEM_ADDR2, MEM_DIN2;
    logic [31:0] MEM_DOUT2 = 32'h0;
    logic [1:0]  MEM_SIZE;

    always #5 CLK = ~CLK;

    otter_lsu #(.IO_BASE(IoBase)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .SIZE(SIZE), .UNS(UNS), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] din;
    } strobe_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_n;
        logic [31:0] exp_a0;
    } vec_t;

    logic [7:0]  mem     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    strobe_t     log_q[$];
    strobe_t     exp_q[$];
    int          both_cnt = 0;
    int          checks = 0, errors = 0;
    logic [31:0] m_rdata = 32'h0;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Memory port: read data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (MEM_READ2)
            MEM_DOUT2 <= {rd_byte(MEM_ADDR2 + 32'd3), rd_byte(MEM_ADDR2 + 32'd2),
                          rd_byte(MEM_ADDR2 + 32'd1), rd_byte(MEM_ADDR2)};
        if (MEM_WRITE2)
            for (int i = 0; i < nbytes(MEM_SIZE); i++)
                mem[MEM_ADDR2 + 32'(i)] = 8'(MEM_DIN2 >> (8 * i));
    end

    always @(negedge CLK) begin
        if (MEM_READ2 && MEM_WRITE2) both_cnt++;
        if (MEM_READ2) log_q.push_back({1'b0, MEM_ADDR2, MEM_SIZE, 32'h0});
        if (MEM_WRITE2) log_q.push_back({1'b1, MEM_ADDR2, MEM_SIZE, MEM_DIN2});
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[a + 32'(i)]     = 8'(w >> (8 * i));
            ref_mem[a + 32'(i)] = 8'(w >> (8 * i));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_strobes(input string name);
        int bad;
        checks++;
        bad = (log_q.size() != exp_q.size()) ? 0 : -1;
        for (int i = 0; bad < 0 && i < exp_q.size(); i++)
            if (log_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            if (log_q.size() != exp_q.size())
                $display("FAIL %s: got %0d strobes expected %0d", name, log_q.size(), exp_q.size());
            else
                $display("FAIL %s: strobe %0d got %h expected %h", name, bad, log_q[bad], exp_q[bad]);
        end
    endtask

    // Reference: plain byte arithmetic on ref_mem, builds the expected strobe list.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic u,
                         output logic [31:0] er, output logic ee, output int el);
        logic        io;
        logic        span;
        int          k;
        logic [31:0] v;
        exp_q.delete();
        io   = a >= IoBase;
        k    = nbytes(sz);
        span = !io && (int'(a[1:0]) + k > 4);
        ee   = 1'b0;
        if (sz == 2'd3) begin
            m_rdata = 32'h0;
            ee = 1'b1;
            el = 0;
        end else if (!we) begin
            v = 32'h0;
            if (io) begin
                for (int i = 0; i < 4; i++) v |= 32'(ref_byte(a + 32'(i))) << (8 * i);
                exp_q.push_back({1'b0, a, 2'd2, 32'h0});
            end else begin
                for (int i = 0; i < k; i++) v |= 32'(ref_byte(a + 32'(i))) << (8 * i);
                if (!u && k == 1) v = {{24{v[7]}}, v[7:0]};
                if (!u && k == 2) v = {{16{v[15]}}, v[15:0]};
                exp_q.push_back({1'b0, a & 32'hFFFFFFFC, 2'd2, 32'h0});
                if (span) exp_q.push_back({1'b0, (a & 32'hFFFFFFFC) + 32'd4, 2'd2, 32'h0});
            end
            m_rdata = v;
            el = span ? 4 : 2;
        end else if (span) begin
            for (int i = 0; i < k; i++) begin
                ref_mem[a + 32'(i)] = 8'(wd >> (8 * i));
                exp_q.push_back({1'b1, a + 32'(i), 2'd0, {24'h0, 8'(wd >> (8 * i))}});
            end
            el = k;
        end else begin
            for (int i = 0; i < (io ? 4 : k); i++) ref_mem[a + 32'(i)] = 8'(wd >> (8 * i));
            exp_q.push_back({1'b1, a, io ? 2'd2 : sz, wd});
            el = 1;
        end
        er = m_rdata;
    endtask

    task automatic do_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic u,
                         output logic [31:0] rdata, output logic err, output int lat);
        @(negedge CLK);
        log_q.delete();
        REQ = 1'b1; WE = we; ADDR = a; WDATA = wd; SIZE = sz; UNS = u;
        @(negedge CLK);
        REQ = 1'b0; WE = 1'($urandom); ADDR = $urandom; WDATA = $urandom;
        SIZE = 2'($urandom); UNS = 1'($urandom);
        lat = 0;
        while (!DONE && lat < 12) begin
            @(negedge CLK);
            lat++;
        end
        if (!DONE) lat = -1;
        rdata = RDATA;
        err   = ERR;
    endtask

    vec_t        vecs[$];
    logic [31:0] rdata, er, a, wd;
    logic        err, ee, we, u, seen;
    logic [1:0]  sz;
    int          lat, el;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        preload(IoBase, 32'h0BADC0DE);
        preload(IoBase + 32'd4, 32'hCAFEF00D);
        preload(IoBase + 32'd8, 32'h13579BDF);
        preload(IoBase + 32'd12, 32'h2468ACE0);

        //        we    addr            wdata          sz    u     rdata          err  lat n a0
        vecs.push_back('{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h44332211, 1'b0, 2, 1, 32'h100});
        vecs.push_back('{1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 32'h66554433, 1'b0, 4, 2, 32'h100});
        vecs.push_back('{1'b0, 32'h107, 32'h0, 2'd0, 1'b0, 32'hFFFFFF88, 1'b0, 2, 1, 32'h104});
        vecs.push_back('{1'b0, 32'h107, 32'h0, 2'd0, 1'b1, 32'h00000088, 1'b0, 2, 1, 32'h104});
        vecs.push_back('{1'b0, 32'h103, 32'h0, 2'd1, 1'b0, 32'h00005544, 1'b0, 4, 2, 32'h100});
        vecs.push_back('{1'b1, 32'h101, 32'h12345678, 2'd2, 1'b0, 32'h00005544, 1'b0, 4, 4, 32'h101});
        vecs.push_back('{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h34567811, 1'b0, 2, 1, 32'h100});
        vecs.push_back('{1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 32'h88776612, 1'b0, 2, 1, 32'h104});
        vecs.push_back('{1'b1, 32'h108, 32'h0000BEEF, 2'd1, 1'b0, 32'h88776612, 1'b0, 1, 1, 32'h108});
        vecs.push_back('{1'b0, 32'h109, 32'h0, 2'd0, 1'b0, 32'hFFFFFFBE, 1'b0, 2, 1, 32'h108});
        vecs.push_back('{1'b0, 32'h11000004, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 2, 1, 32'h11000004});
        vecs.push_back('{1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 32'h00000000, 1'b1, 0, 0, 32'h0});

        // Reset state
        REQ = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", {31'h0, BUSY}, 32'h0);
        chk("reset_done_err", {30'h0, DONE, ERR}, 32'h0);
        chk("reset_strobes", {30'h0, MEM_READ2, MEM_WRITE2}, 32'h0);
        chk("reset_addr", MEM_ADDR2, 32'h0);
        chk("reset_rdata", RDATA, 32'h0);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rdata, err, lat);
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, er, ee, el);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_nstrobes", i), 32'(log_q.size()), 32'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0 && log_q.size() > 0)
                chk($sformatf("vec%0d_addr0", i), log_q[0].addr, vecs[i].exp_a0);
            chk_strobes($sformatf("vec%0d_strobes", i));
        end

        // Reset while in CAP_LO of a spanning load: abandoned, no RD_HI, no DONE
        @(negedge CLK);
        log_q.delete();
        REQ = 1'b1; WE = 1'b0; ADDR = 32'h102; SIZE = 2'd2; UNS = 1'b0;
        @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
        chk("caplo_busy", {31'h0, BUSY}, 32'h1);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_busy", {31'h0, BUSY}, 32'h0);
        chk("abort_rdata_cleared", RDATA, 32'h0);
        RST_N = 1'b1;
        m_rdata = 32'h0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (DONE) seen = 1'b1;
        end
        chk("abort_no_done", {31'h0, seen}, 32'h0);
        chk("abort_strobe_count", 32'(log_q.size()), 32'd1);

        // REQ held high through reset is taken on the first edge with RST_N high
        RST_N = 1'b0;
        log_q.delete();
        REQ = 1'b1; WE = 1'b0; ADDR = 32'h104; SIZE = 2'd2; UNS = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rstreq_busy", {31'h0, BUSY}, 32'h0);
        chk("rstreq_strobes", 32'(log_q.size()), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        chk("rstreq_accepted", {31'h0, BUSY}, 32'h1);
        lat = 0;
        while (!DONE && lat < 12) begin
            @(negedge CLK);
            lat++;
        end
        model(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, er, ee, el);
        chk("rstreq_latency", 32'(lat), 32'd2);
        chk("rstreq_rdata", RDATA, er);

        // REQ asserted during RESP is ignored
        do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b1, rdata, err, lat);
        model(1'b0, 32'h100, 32'h0, 2'd2, 1'b1, er, ee, el);
        chk("resp_load_rdata", rdata, er);
        log_q.delete();
        REQ = 1'b1; WE = 1'b1; ADDR = 32'h100; WDATA = 32'hDEADBEEF; SIZE = 2'd2;
        @(negedge CLK);
        REQ = 1'b0;
        chk("resp_req_ignored", {31'h0, BUSY}, 32'h0);
        repeat (3) @(negedge CLK);
        chk("resp_req_no_strobes", 32'(log_q.size()), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom);
            u  = 1'($urandom);
            wd = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = IoBase + 32'(4 * $urandom_range(0, 3));
            else a = 32'h100 + 32'($urandom_range(0, 15));
            do_op(we, a, wd, sz, u, rdata, err, lat);
            model(we, a, wd, sz, u, er, ee, el);
            chk($sformatf("rnd%0d_rdata", n), rdata, er);
            chk($sformatf("rnd%0d_err", n), {31'h0, err}, {31'h0, ee});
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(el));
            chk_strobes($sformatf("rnd%0d_strobes", n));
        end

        chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
